// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the FSM state encoding
//   and the default operand width.
//   No ports (package).
package serial_adder_pkg;

  // Default operand / sum width in bits (legal range 2..32).
  localparam int DEFAULT_WIDTH = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_bit.sv
// fa_bit
//   Purely combinational single-bit full adder.
//   Ports:
//     a, b  : addend bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_bit

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
//   processing one bit per clock, LSB first.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : request, honoured only in IDLE or DONE
//     a, b   : operands, captured on an accepted start
//     cin    : carry-in, captured on an accepted start
//     busy   : high while the add is in progress (state RUN)
//     done   : one-cycle pulse when sum/cout become valid
//     sum    : registered result, held until the next completion
//     cout   : registered carry-out, held with sum
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] s_sr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_s_s;
  logic             fa_co_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] s_next_s;

  // Single full-adder cell shared by every bit position.
  fa_bit u_fa (
    .a  (a_sr_r[0]),
    .b  (b_sr_r[0]),
    .ci (carry_r),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // Sum shift register after the current bit is inserted at the MSB end.
  assign s_next_s = {fa_s_s, s_sr_r[WIDTH-1:1]};

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        // Back-to-back: DONE accepts a new request without an IDLE gap.
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, serial shift/add, and result latch on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      s_sr_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      a_sr_r  <= a;
      b_sr_r  <= b;
      s_sr_r  <= {WIDTH{1'b0}};
      carry_r <= cin;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      a_sr_r  <= a_sr_r >> 1;
      b_sr_r  <= b_sr_r >> 1;
      s_sr_r  <= s_next_s;
      carry_r <= fa_co_s;
      cnt_r   <= cnt_r + CNT_W'(1);
      // The final bit edge publishes the complete result in the same clock.
      if (last_s) begin
        sum_r  <= s_next_s;
        cout_r <= fa_co_s;
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
      end
    end else begin
      a_sr_r  <= a_sr_r;
      b_sr_r  <= b_sr_r;
      s_sr_r  <= s_sr_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  // Status flags decode the state flop only, so they can never overlap.
  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule : serial_adder_fsm

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm
//   Directed and randomised checks of serial_adder_fsm at WIDTH=8 and 16.
module tb_serial_adder_fsm;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16;
  logic [15:0] a16, b16;
  logic        cin16;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  prev8    = 9'd0;

  always #5 clk = ~clk;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_fsm #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit add; optional start re-pulse (with zeroed operands) in RUN.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input bit repulse);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);                       // E0 has sampled start
    for (int i = 1; i <= 20 && done_at == 0; i++) begin
      if (i > 1) @(negedge clk);
      if (repulse && i == 3) begin
        a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      check("busy_done_excl8", {63'd0, busy8 & done8}, 64'd0);
      if (busy8) begin
        busy_n++;
        check("hold8", {55'd0, cout8, sum8}, {55'd0, prev8});
      end
      if (done8) done_at = i;
    end
    check("latency8", done_at, 9);
    check("busy_cycles8", busy_n, 8);
    check("sum8", {56'd0, sum8}, {56'd0, es});
    check("cout8", {63'd0, cout8}, {63'd0, ec});
    prev8 = {ec, es};
    @(negedge clk);
    check("done_pulse8", {63'd0, done8}, 64'd0);
  endtask

  // One 16-bit add against the behavioural sum.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    logic [16:0] exp;
    int done_at;
    exp     = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    done_at = 0;
    @(negedge clk);
    a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 1; i <= 30 && done_at == 0; i++) begin
      if (i > 1) @(negedge clk);
      check("busy_done_excl16", {63'd0, busy16 & done16}, 64'd0);
      if (done16) done_at = i;
    end
    check("latency16", done_at, 17);
    check("sum16", {47'd0, cout16, sum16}, {47'd0, exp});
  endtask

  initial begin
    int done_n;
    int next_done;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] rexp;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_sum", {55'd0, cout8, sum8}, 64'd0);
    check("rst_state16", {45'd0, busy16, done16, cout16, sum16}, 64'd0);
    rst_n = 1'b1;

    // Directed vectors.
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    run8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b1);

    // Start held high: back-to-back adds with no IDLE gap.
    done_n    = 0;
    next_done = 9;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      check("busy_done_excl_hold", {63'd0, busy8 & done8}, 64'd0);
      if (done8) begin
        done_n++;
        check("hold_done_cycle", i, next_done);
        check("hold_sum", {55'd0, cout8, sum8}, 64'h002);
        next_done += 9;
      end
      if (i == 27) start8 = 1'b0;
    end
    check("hold_done_count", done_n, 3);
    @(negedge clk);
    check("hold_idle", {62'd0, busy8, done8}, 64'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy8}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy8}, 64'd0);
    check("arst_done", {63'd0, done8}, 64'd0);
    check("arst_sum", {56'd0, sum8}, 64'd0);
    check("arst_cout", {63'd0, cout8}, 64'd0);
    #1;
    rst_n = 1'b1;
    prev8  = 9'd0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) done_n++;
    end
    check("no_done_after_abort", done_n, 0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random sweeps.
    for (int k = 0; k < 1000; k++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run8(ra, rb, rc, rexp[7:0], rexp[8], 1'b0);
    end
    for (int k = 0; k < 1000; k++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_fsm
